// File: rtl/ccc_clock_supervisor.sv
// Clock supervisor on the CCC global clock: qualifies PLL lock, then emits
// phase-aligned per-channel clock enables and a synchronous fabric reset.
module ccc_clock_supervisor #(
    parameter int NUM_CH             = 4,
    parameter int DIV_W              = 8,
    parameter int LOCK_STABLE_CYCLES = 16,
    parameter int LOSS_W             = 8
) (
    input  logic                    CLK0,
    input  logic                    ARST_N,
    input  logic                    LOCK,
    input  logic [NUM_CH*DIV_W-1:0] DIV_RATIO,
    input  logic                    SYNC_REQ,
    input  logic                    LOSS_CLR,
    output logic [NUM_CH-1:0]       CE,
    output logic                    READY,
    output logic                    FABRIC_RST_N,
    output logic [LOSS_W-1:0]       LOSS_COUNT,
    output logic [1:0]              STATE
);

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_SETTLE    = 2'd1,
        ST_RUN       = 2'd2,
        ST_LOST      = 2'd3
    } state_t;

    localparam int SET_W = (LOCK_STABLE_CYCLES < 2) ? 1 : $clog2(LOCK_STABLE_CYCLES + 1);
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(LOCK_STABLE_CYCLES - 1);

    state_t              state_reg, state_next;
    logic [SET_W-1:0]    settle_reg, settle_next;
    logic [LOSS_W-1:0]   loss_reg, loss_next;
    logic                lock_meta_reg, lock_s_reg;
    logic                ready_reg;
    logic                loss_inc;
    logic                run_entry, run_stay, realign;
    logic [NUM_CH-1:0]   ce_reg, ce_next;

    always_ff @(posedge CLK0 or negedge ARST_N) begin
        if (!ARST_N) begin
            lock_meta_reg <= 1'b0;
            lock_s_reg    <= 1'b0;
        end else begin
            lock_meta_reg <= LOCK;
            lock_s_reg    <= lock_meta_reg;
        end
    end

    always_comb begin
        state_next  = state_reg;
        settle_next = settle_reg;
        loss_inc    = 1'b0;
        case (state_reg)
            ST_WAIT_LOCK: begin
                settle_next = '0;
                if (lock_s_reg) state_next = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (!lock_s_reg) begin
                    state_next  = ST_WAIT_LOCK;
                    settle_next = '0;
                end else if (settle_reg == SETTLE_LAST) begin
                    state_next  = ST_RUN;
                    settle_next = '0;
                end else begin
                    settle_next = settle_reg + SET_W'(1);
                end
            end
            ST_RUN: begin
                if (!lock_s_reg) begin
                    state_next = ST_LOST;
                    loss_inc   = 1'b1;
                end
            end
            ST_LOST:  state_next = ST_WAIT_LOCK;
            default:  state_next = ST_WAIT_LOCK;
        endcase
    end

    // A clear coinciding with a new loss leaves exactly that loss counted.
    always_comb begin
        loss_next = loss_reg;
        if (LOSS_CLR)
            loss_next = loss_inc ? LOSS_W'(1) : '0;
        else if (loss_inc && !(&loss_reg))
            loss_next = loss_reg + LOSS_W'(1);
    end

    assign run_entry = (state_next == ST_RUN) && (state_reg != ST_RUN);
    assign run_stay  = (state_next == ST_RUN) && (state_reg == ST_RUN);
    assign realign   = run_entry || (run_stay && SYNC_REQ);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [DIV_W-1:0] div_raw, ratio_eff;
            logic [DIV_W-1:0] ratio_reg, ratio_next;
            logic [DIV_W-1:0] cnt_reg, cnt_next;
            logic             ce_ch_next;

            assign div_raw   = DIV_RATIO[gi*DIV_W +: DIV_W];
            assign ratio_eff = (div_raw == '0) ? DIV_W'(1) : div_raw;

            // The ratio only reloads on the edge that raises CE, so a period
            // in progress always completes with the ratio it started with.
            always_comb begin
                cnt_next   = '0;
                ratio_next = ratio_eff;
                ce_ch_next = 1'b0;
                if (realign) begin
                    ce_ch_next = 1'b1;
                end else if (run_stay) begin
                    if (cnt_reg == ratio_reg - DIV_W'(1)) begin
                        ce_ch_next = 1'b1;
                    end else begin
                        cnt_next   = cnt_reg + DIV_W'(1);
                        ratio_next = ratio_reg;
                    end
                end
            end

            always_ff @(posedge CLK0 or negedge ARST_N) begin
                if (!ARST_N) begin
                    cnt_reg   <= '0;
                    ratio_reg <= DIV_W'(1);
                end else begin
                    cnt_reg   <= cnt_next;
                    ratio_reg <= ratio_next;
                end
            end

            assign ce_next[gi] = ce_ch_next;
        end
    endgenerate

    always_ff @(posedge CLK0 or negedge ARST_N) begin
        if (!ARST_N) begin
            state_reg  <= ST_WAIT_LOCK;
            settle_reg <= '0;
            loss_reg   <= '0;
            ready_reg  <= 1'b0;
            ce_reg     <= '0;
        end else begin
            state_reg  <= state_next;
            settle_reg <= settle_next;
            loss_reg   <= loss_next;
            ready_reg  <= (state_next == ST_RUN);
            ce_reg     <= ce_next;
        end
    end

    assign CE           = ce_reg;
    assign READY        = ready_reg;
    assign FABRIC_RST_N = ready_reg;
    assign LOSS_COUNT   = loss_reg;
    assign STATE        = state_reg;

endmodule

// File: tb/tb_ccc_clock_supervisor.sv
// Directed bench for ccc_clock_supervisor: lock-up latency, divide patterns,
// glitchless reload, realign, lock loss/saturation, settle abort, async reset.
module tb_ccc_clock_supervisor;

    logic        CLK0 = 1'b0;
    logic        ARST_N;
    logic        LOCK;
    logic [31:0] DIV_RATIO;
    logic        SYNC_REQ;
    logic        LOSS_CLR;
    logic [3:0]  CE;
    logic        READY;
    logic        FABRIC_RST_N;
    logic [7:0]  LOSS_COUNT;
    logic [1:0]  STATE;

    int tests_run = 0;
    int tests_failed = 0;

    ccc_clock_supervisor #(
        .NUM_CH(4), .DIV_W(8), .LOCK_STABLE_CYCLES(16), .LOSS_W(8)
    ) dut (
        .CLK0(CLK0), .ARST_N(ARST_N), .LOCK(LOCK), .DIV_RATIO(DIV_RATIO),
        .SYNC_REQ(SYNC_REQ), .LOSS_CLR(LOSS_CLR), .CE(CE), .READY(READY),
        .FABRIC_RST_N(FABRIC_RST_N), .LOSS_COUNT(LOSS_COUNT), .STATE(STATE)
    );

    initial forever #5 CLK0 = ~CLK0;

    task automatic tick();
        @(posedge CLK0);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic wait_for_state(input logic [1:0] s, input int budget, input string tag);
        int n = 0;
        while (STATE !== s && n < budget) begin
            tick();
            n++;
        end
        check(tag, {30'd0, STATE}, {30'd0, s});
    endtask

    task automatic lose_once();
        LOCK = 1'b1;
        wait_for_state(2'd2, 40, "relock_run");
        LOCK = 1'b0;
        wait_for_state(2'd3, 10, "loss_lost");
        tick();
    endtask

    initial begin
        logic [3:0] exp_ce;

        ARST_N    = 1'b0;
        LOCK      = 1'b0;
        SYNC_REQ  = 1'b0;
        LOSS_CLR  = 1'b0;
        DIV_RATIO = {8'd5, 8'd3, 8'd1, 8'd0};
        tick();
        tick();
        check("rst_state", {30'd0, STATE}, 32'd0);
        check("rst_ce", {28'd0, CE}, 32'd0);
        check("rst_ready", {31'd0, READY}, 32'd0);
        check("rst_frst", {31'd0, FABRIC_RST_N}, 32'd0);
        check("rst_loss", {24'd0, LOSS_COUNT}, 32'd0);

        // Lock-up latency: edge 1 samples LOCK high.
        ARST_N = 1'b1;
        LOCK   = 1'b1;
        tick();
        check("edge1_state", {30'd0, STATE}, 32'd0);
        tick();
        check("edge2_state", {30'd0, STATE}, 32'd0);
        for (int e = 3; e <= 18; e++) begin
            tick();
            check($sformatf("settle_e%0d_state", e), {30'd0, STATE}, 32'd1);
            check($sformatf("settle_e%0d_ready", e), {31'd0, READY}, 32'd0);
        end
        tick();
        check("edge19_state", {30'd0, STATE}, 32'd2);
        check("edge19_ready", {31'd0, READY}, 32'd1);
        check("edge19_frst", {31'd0, FABRIC_RST_N}, 32'd1);
        check("edge19_ce", {28'd0, CE}, 32'h0000000F);

        // Divide pattern {0,1,3,5}, cycle 0 is the first RUN cycle.
        for (int k = 1; k <= 15; k++) begin
            tick();
            exp_ce = {(k % 5 == 0), (k % 3 == 0), 2'b11};
            check($sformatf("div_c%0d", k), {28'd0, CE}, {28'd0, exp_ce});
        end

        // Glitchless reload: ch3 ratio 5 -> 2 two cycles after its CE at 15.
        tick();
        tick();
        DIV_RATIO = {8'd2, 8'd3, 8'd1, 8'd0};
        for (int k = 18; k <= 24; k++) begin
            tick();
            check($sformatf("reload_c%0d_ce3", k), {31'd0, CE[3]},
                  {31'd0, (k == 20 || k == 22 || k == 24)});
        end

        // Realign at an off phase for ch2.
        tick();
        SYNC_REQ = 1'b1;
        tick();
        SYNC_REQ = 1'b0;
        check("sync_ce", {28'd0, CE}, 32'h0000000F);
        for (int j = 1; j <= 6; j++) begin
            tick();
            exp_ce = {(j % 2 == 0), (j % 3 == 0), 2'b11};
            check($sformatf("sync_c%0d", j), {28'd0, CE}, {28'd0, exp_ce});
        end

        // Lock loss: two synchroniser edges, then RUN -> LOST.
        check("preloss_count", {24'd0, LOSS_COUNT}, 32'd0);
        LOCK = 1'b0;
        tick();
        tick();
        check("loss_b_state", {30'd0, STATE}, 32'd2);
        tick();
        check("loss_state", {30'd0, STATE}, 32'd3);
        check("loss_ce", {28'd0, CE}, 32'd0);
        check("loss_ready", {31'd0, READY}, 32'd0);
        check("loss_frst", {31'd0, FABRIC_RST_N}, 32'd0);
        check("loss_count1", {24'd0, LOSS_COUNT}, 32'd1);
        tick();
        check("lost_to_wait", {30'd0, STATE}, 32'd0);

        // Saturation.
        for (int r = 0; r < 253; r++) lose_once();
        check("loss_count254", {24'd0, LOSS_COUNT}, 32'd254);
        lose_once();
        check("loss_count255", {24'd0, LOSS_COUNT}, 32'd255);
        lose_once();
        check("loss_saturate", {24'd0, LOSS_COUNT}, 32'd255);

        // Settle abort: one-cycle LOCK glitch mid-SETTLE.
        LOCK = 1'b1;
        wait_for_state(2'd1, 10, "abort_settle_enter");
        for (int n = 0; n < 4; n++) begin
            tick();
            check("abort_pre_ready", {31'd0, READY}, 32'd0);
        end
        LOCK = 1'b0;
        tick();
        LOCK = 1'b1;
        check("abort_a_ready", {31'd0, READY}, 32'd0);
        tick();
        check("abort_b_ready", {31'd0, READY}, 32'd0);
        tick();
        check("abort_wait_state", {30'd0, STATE}, 32'd0);
        check("abort_ready", {31'd0, READY}, 32'd0);
        check("abort_loss", {24'd0, LOSS_COUNT}, 32'd255);
        tick();
        check("abort_resettle", {30'd0, STATE}, 32'd1);
        for (int n = 1; n <= 15; n++) begin
            tick();
            check($sformatf("resettle_%0d_ready", n), {31'd0, READY}, 32'd0);
        end
        tick();
        check("resettle_run", {30'd0, STATE}, 32'd2);
        check("resettle_ready", {31'd0, READY}, 32'd1);

        // LOSS_CLR coincident with a loss.
        LOCK = 1'b0;
        tick();
        tick();
        LOSS_CLR = 1'b1;
        tick();
        LOSS_CLR = 1'b0;
        check("clr_loss_state", {30'd0, STATE}, 32'd3);
        check("clr_loss_count", {24'd0, LOSS_COUNT}, 32'd1);
        tick();

        // Async reset mid-RUN.
        LOCK = 1'b1;
        wait_for_state(2'd2, 40, "relock_final");
        tick();
        check("prereset_ce", {30'd0, CE[1:0]}, 32'd3);
        #2;
        ARST_N = 1'b0;
        #1;
        check("arst_ce", {28'd0, CE}, 32'd0);
        check("arst_ready", {31'd0, READY}, 32'd0);
        check("arst_frst", {31'd0, FABRIC_RST_N}, 32'd0);
        check("arst_state", {30'd0, STATE}, 32'd0);
        check("arst_loss", {24'd0, LOSS_COUNT}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
